// File: rtl/riscv_m_pkg.sv
// rtl/riscv_m_pkg.sv - shared constants and state encoding for the RV32M divide front end
package riscv_m_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SPEC = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/divu_iter.sv
// rtl/divu_iter.sv - restoring radix-2 unsigned divider, one quotient bit per cycle
module divu_iter
    import riscv_m_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);

    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    // Shifted partial remainder needs one extra bit before the trial subtract.
    logic [XLEN:0]    shifted;
    logic             fits;

    // Next-state: load on start, otherwise shift in one quotient bit per cycle.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[XLEN-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        if (start) begin
            rem_d = '0;
            quo_d = a;
            dvs_d = b;
            cnt_d = CNT_W'(XLEN);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                // The kept remainder is always below the divisor, so XLEN bits hold it.
                rem_d = fits ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], fits};
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign q    = quo_q;
    assign r    = rem_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - RV32M DIV/DIVU/REM/REMU issue control, sign handling and special cases
module div_issue_ctrl
    import riscv_m_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_e      state_q, state_d;
    logic            op_rem_q, op_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            spec_q, spec_d;
    logic            div0_q, div0_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            signed_op;
    logic            rem_op;
    logic            div0;
    logic            ovf;
    logic            accept;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    logic            divu_start;
    logic            divu_done;
    logic [XLEN-1:0] divu_q;
    logic [XLEN-1:0] divu_r;

    // Operand decode, absolute values and special-case detection on the raw request.
    always_comb begin
        signed_op = (funct3 == F3_DIV) || (funct3 == F3_REM);
        rem_op    = (funct3 == F3_REM) || (funct3 == F3_REMU);
        abs1      = (signed_op && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2      = (signed_op && rs2[XLEN-1]) ? -rs2 : rs2;
        div0      = (rs2 == '0);
        ovf       = signed_op && (rs1 == MIN_INT) && (rs2 == '1);
        accept    = (state_q == IDLE) && start && funct3[2] && !flush;
        quo_fix   = neg_quo_q ? -divu_q : divu_q;
        rem_fix   = neg_rem_q ? -divu_r : divu_r;
    end

    // Control FSM next-state and outputs; flush overrides everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        op_rem_d   = op_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        spec_d     = spec_q;
        div0_d     = div0_q;
        rs1_d      = rs1_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        divu_start = 1'b0;
        done       = 1'b0;
        busy       = (state_q == SPEC) || (state_q == RUN) || (state_q == FIX);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_rem_d  = rem_op;
                    neg_quo_d = signed_op && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                    neg_rem_d = signed_op && rs1[XLEN-1];
                    spec_d    = div0 || ovf;
                    div0_d    = div0;
                    rs1_d     = rs1;
                    if (div0 || ovf) begin
                        state_d = SPEC;
                    end else begin
                        state_d    = RUN;
                        divu_start = 1'b1;
                    end
                end
            end
            SPEC: begin
                if (div0_q) begin
                    spec_res_d = op_rem_q ? rs1_q : '1;
                end else begin
                    spec_res_d = op_rem_q ? '0 : MIN_INT;
                end
                state_d = FIX;
            end
            RUN: begin
                if (divu_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = spec_q ? spec_res_q : (op_rem_q ? rem_fix : quo_fix);
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A fresh divider start aborts any iteration still in progress.
        if (flush && (state_q != IDLE)) begin
            state_d    = IDLE;
            result_d   = result_q;
            done       = 1'b0;
            divu_start = 1'b1;
        end
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
            div0_q     <= 1'b0;
            rs1_q      <= '0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_rem_q   <= op_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            spec_q     <= spec_d;
            div0_q     <= div0_d;
            rs1_q      <= rs1_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    assign result = result_q;

    divu_iter u_divu_iter (
        .clk   (clk),
        .rst   (rst),
        .start (divu_start),
        .a     (abs1),
        .b     (abs2),
        .done  (divu_done),
        .q     (divu_q),
        .r     (divu_r)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed and random checks of div_issue_ctrl against an arithmetic model
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int nvec  = 0;
    int nfail = 0;

    div_issue_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        return (b == 32'd0) || (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    // Arithmetic reference: SV signed division truncates toward zero and % follows the dividend.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (f3)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, check acceptance delay, completion latency and result.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int exp_acc, input bit poke);
        int n;
        int exp_lat;
        logic [31:0] exp_res;
        exp_res = ref_model(f3, a, b);
        exp_lat = is_special(f3, a, b) ? 2 : 35;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 10);
        start = 1'b0;
        chk({tag, " accept_delay"}, n, exp_acc);
        if (poke) begin
            funct3 = 3'b101;
            rs1    = 32'd8;
            rs2    = 32'd2;
        end
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (poke) start = (n >= 2 && n < 6);
            tick();
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " result"}, result, exp_res);
    endtask

    initial begin
        int pulses;
        logic [31:0] saved;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        int sel;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        rs1    = '0;
        rs2    = '0;
        flush  = 1'b0;
        tick();
        tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        // MUL-group request is ignored.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b000;
        rs1    = 32'd6;
        rs2    = 32'd3;
        tick();
        start = 1'b0;
        chk("mul ignored busy", busy, 0);
        tick();
        chk("mul ignored busy2", busy, 0);
        chk("mul ignored done", done, 0);

        // flush together with start in IDLE drops the request.
        @(negedge clk);
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b101;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start busy", busy, 0);

        do_op("divu 100/7", 3'b101, 32'd100, 32'd7, 1, 1'b0);
        do_op("remu 100/7", 3'b111, 32'd100, 32'd7, 2, 1'b0);
        do_op("div -7/2",   3'b100, 32'hFFFF_FFF9, 32'd2, 2, 1'b0);
        do_op("rem -7/2",   3'b110, 32'hFFFF_FFF9, 32'd2, 2, 1'b0);
        do_op("rem 7/-2",   3'b110, 32'd7, 32'hFFFF_FFFE, 2, 1'b0);
        do_op("div ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
        do_op("rem ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
        do_op("divu 5/0",   3'b101, 32'd5, 32'd0, 2, 1'b0);
        do_op("remu 5/0",   3'b111, 32'd5, 32'd0, 2, 1'b0);
        do_op("div min/2",  3'b100, 32'h8000_0000, 32'd2, 2, 1'b0);

        // start while busy is ignored; only one done pulse.
        do_op("busy_ignore", 3'b101, 32'd100, 32'd7, 2, 1'b1);
        tick();
        chk("busy_ignore done single", done, 0);
        chk("busy_ignore idle", busy, 0);

        // flush mid-operation.
        saved = result;
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b101;
        rs1    = 32'hFFFF_FFFF;
        rs2    = 32'd3;
        tick();
        start = 1'b0;
        chk("flush accepted", busy, 1);
        repeat (9) tick();
        @(negedge clk);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush done", done, 0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        chk("flush no done", pulses, 0);
        chk("flush result kept", result, saved);
        do_op("divu 9/3 after flush", 3'b101, 32'd9, 32'd3, 1, 1'b0);

        // reset during an op.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b100;
        rs1    = 32'd1000;
        rs2    = 32'd7;
        tick();
        start = 1'b0;
        repeat (19) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midop rst busy", busy, 0);
        chk("midop rst done", done, 0);
        chk("midop rst result", result, 0);
        do_op("div after rst", 3'b100, 32'd1000, 32'hFFFF_FFF9, 1, 1'b0);

        // Random back-to-back ops.
        for (int i = 0; i < 1200; i++) begin
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            f3  = 3'b100 | 3'($urandom_range(0, 3));
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(0, 15));
                3: begin a = 32'($urandom_range(0, 999)); b = 32'($urandom_range(1, 50)); end
                4: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op($sformatf("rand%0d f3=%b a=%h b=%h", i, f3, a, b), f3, a, b, 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
